cordic_p2r: RTL and testbench

Iterative polar-to-rectangular CORDIC (rotation mode): takes a magnitude and a 19-bit phase, returns the X/Y components. It is the inverse of the team's pipelined rectangular-to-polar CORDIC and uses the same phase convention, angle table, working width and rounding. It is sequential rather than pipelined: one micro-rotation per clock, with a strobe/busy handshake, for control paths where area matters more than throughput.

---
 rtl/cordic_pkg.sv | 47 ++++
 rtl/cordic_round.sv | 23 ++
 rtl/cordic_p2r.sv | 144 ++++++++++++++
 tb/tb_cordic_p2r.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: working/phase widths, arctangent table, octant phases and gain.
// Used by both the polar-to-rectangular and rectangular-to-polar blocks.
package cordic_pkg;

    localparam int unsigned WW      = 18;
    localparam int unsigned PW      = 19;
    localparam int unsigned NSTAGES = 16;

    localparam logic [PW-1:0] PHASE_45 = 19'h10000;
    localparam logic [PW-1:0] PHASE_90 = 19'h20000;

    // Accumulated micro-rotation gain, left uncompensated in the datapath.
    localparam real         CORDIC_GAIN     = 1.164435;
    localparam logic [31:0] CORDIC_INV_GAIN = 32'hdbd95b16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROTATE,
        ST_ROUND
    } p2r_state_t;

    // atan(2^-(idx+1)) on a 2^PW full circle, truncated toward zero.
    function automatic logic [PW-1:0] cordic_angle(input logic [3:0] i_idx);
        logic [PW-1:0] w_ang;
        w_ang = '0;
        case (i_idx)
            4'd0:    w_ang = 19'h09720;
            4'd1:    w_ang = 19'h04fd9;
            4'd2:    w_ang = 19'h02888;
            4'd3:    w_ang = 19'h01458;
            4'd4:    w_ang = 19'h00a2e;
            4'd5:    w_ang = 19'h00517;
            4'd6:    w_ang = 19'h0028b;
            4'd7:    w_ang = 19'h00145;
            4'd8:    w_ang = 19'h000a2;
            4'd9:    w_ang = 19'h00051;
            4'd10:   w_ang = 19'h00028;
            4'd11:   w_ang = 19'h00014;
            4'd12:   w_ang = 19'h0000a;
            4'd13:   w_ang = 19'h00005;
            4'd14:   w_ang = 19'h00002;
            default: w_ang = 19'h00001;
        endcase
        return w_ang;
    endfunction

endpackage

// File: rtl/cordic_round.sv
// Combinational round-half-to-even from IW to OW bits (keeps the top OW bits).
module cordic_round #(
    parameter int unsigned IW = 18,
    parameter int unsigned OW = 12
) (
    input  logic [IW-1:0] i_val,
    output logic [OW-1:0] o_val
);

    localparam int unsigned FW = IW - OW;
    localparam logic [FW-1:0] HALF = {1'b1, {(FW-1){1'b0}}};

    logic [FW-1:0] w_frac;
    logic          w_lsb;
    logic          w_up;

    // Carry-out of adding {lsb, !lsb...} to the fraction, written as a compare.
    assign w_frac = i_val[FW-1:0];
    assign w_lsb  = i_val[FW];
    assign w_up   = (w_frac > HALF) || ((w_frac == HALF) && w_lsb);
    assign o_val  = i_val[IW-1:FW] + {{(OW-1){1'b0}}, w_up};

endmodule

// File: rtl/cordic_p2r.sv
// Iterative rotation-mode CORDIC: (magnitude, phase) -> (X, Y), one micro-rotation per clock.
// Results carry the uncompensated CORDIC gain and a /4 scale.
module cordic_p2r
    import cordic_pkg::*;
#(
    parameter int unsigned IW = 12,
    parameter int unsigned OW = 12
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_stb,
    input  logic [IW-1:0] i_mag,
    input  logic [PW-1:0] i_phase,
    input  logic          i_aux,
    output logic          o_busy,
    output logic          o_valid,
    output logic [OW-1:0] o_xval,
    output logic [OW-1:0] o_yval,
    output logic          o_aux
);

    p2r_state_t r_state;
    p2r_state_t w_next;

    logic signed [WW-1:0] r_x;
    logic signed [WW-1:0] r_y;
    logic signed [PW-1:0] r_z;
    logic [3:0]           r_iter;
    logic [OW-1:0]        r_xval;
    logic [OW-1:0]        r_yval;
    logic                 r_valid;
    logic                 r_aux;

    logic signed [WW-1:0] w_ext;
    logic signed [WW-1:0] w_x0;
    logic signed [WW-1:0] w_y0;
    logic signed [WW-1:0] w_dx;
    logic signed [WW-1:0] w_dy;
    logic [1:0]           w_q;
    logic [PW-1:0]        w_z0;
    logic [PW-1:0]        w_angle;
    logic [4:0]           w_shift;
    logic [OW-1:0]        w_xrnd;
    logic [OW-1:0]        w_yrnd;

    assign w_ext   = {{2{i_mag[IW-1]}}, i_mag, {(WW-IW-2){1'b0}}};
    // Quadrant of (phase + 45deg): adding PHASE_45 only carries bit PW-3 into the top two bits.
    assign w_q     = i_phase[PW-1:PW-2] + {1'b0, i_phase[PW-3]};
    assign w_z0    = i_phase - (PW'(w_q) * PHASE_90);
    assign w_angle = cordic_angle(r_iter);
    assign w_shift = {1'b0, r_iter} + 5'd1;
    assign w_dx    = r_y >>> w_shift;
    assign w_dy    = r_x >>> w_shift;

    always_comb begin
        w_x0 = '0;
        w_y0 = '0;
        case (w_q)
            2'd0:    w_x0 = w_ext;
            2'd1:    w_y0 = w_ext;
            2'd2:    w_x0 = -w_ext;
            default: w_y0 = -w_ext;
        endcase
    end

    cordic_round #(.IW(WW), .OW(OW)) u_round_x (
        .i_val (r_x),
        .o_val (w_xrnd)
    );

    cordic_round #(.IW(WW), .OW(OW)) u_round_y (
        .i_val (r_y),
        .o_val (w_yrnd)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_stb) w_next = ST_ROTATE;
            ST_ROTATE: if (r_iter == 4'(NSTAGES - 1)) w_next = ST_ROUND;
            ST_ROUND:  w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            r_xval  <= '0;
            r_yval  <= '0;
            r_valid <= 1'b0;
            r_aux   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_stb) begin
                        r_aux  <= i_aux;
                        r_x    <= w_x0;
                        r_y    <= w_y0;
                        r_z    <= w_z0;
                        r_iter <= '0;
                    end
                end
                ST_ROTATE: begin
                    if (!r_z[PW-1]) begin
                        r_x <= r_x - w_dx;
                        r_y <= r_y + w_dy;
                        r_z <= r_z - $signed(w_angle);
                    end else begin
                        r_x <= r_x + w_dx;
                        r_y <= r_y - w_dy;
                        r_z <= r_z + $signed(w_angle);
                    end
                    r_iter <= r_iter + 4'd1;
                end
                ST_ROUND: begin
                    r_xval  <= w_xrnd;
                    r_yval  <= w_yrnd;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy  = (r_state != ST_IDLE);
    assign o_valid = r_valid;
    assign o_xval  = r_xval;
    assign o_yval  = r_yval;
    assign o_aux   = r_aux;

endmodule

// File: tb/tb_cordic_p2r.sv
// Self-checking bench for cordic_p2r: vector table, handshake/reset sequences, random sweep vs real model.
module tb_cordic_p2r;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stb = 1'b0;
    logic        aux_in = 1'b0;
    logic [11:0] mag = '0;
    logic [18:0] ph = '0;
    logic        busy, valid, aux_out;
    logic [11:0] xval, yval;

    always #5 clk = ~clk;

    cordic_p2r #(.IW(12), .OW(12)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_stb     (stb),
        .i_mag     (mag),
        .i_phase   (ph),
        .i_aux     (aux_in),
        .o_busy    (busy),
        .o_valid   (valid),
        .o_xval    (xval),
        .o_yval    (yval),
        .o_aux     (aux_out)
    );

    typedef struct {
        int   ex_m;
        int   ey_m;
        logic aux;
    } exp_t;

    typedef struct {
        int          m;
        logic [18:0] p;
        logic        a;
        int          ex;
        int          ey;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[10];

    int   n_checks = 0;
    int   n_pass = 0;
    int   n_results = 0;
    int   cyc = 0;
    int   last_valid_cyc = 0;
    logic prev_valid = 1'b0;
    real  gain = 1.0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input bit ok, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void check_near(input string name, input int act, input int req_m);
        n_checks++;
        if (iabs(act * 1000 - req_m) <= 1000) n_pass++;
        else $display("FAIL %s: got %0d, required %0d/1000 +-1", name, act, req_m);
    endfunction

    function automatic int model_m(input int m, input logic [18:0] p, input bit is_y);
        real a, v;
        a = 2.0 * 3.14159265358979 * real'(p) / 524288.0;
        v = real'(m) * gain * (is_y ? $sin(a) : $cos(a)) / 4.0;
        return int'(v * 1000.0);
    endfunction

    always @(negedge clk) begin
        if (valid) begin
            check("valid_back_to_back", !prev_valid, int'(prev_valid), 0);
            check("busy_with_valid", !busy, int'(busy), 0);
            if (sb.size() == 0) begin
                check("unexpected_valid", 1'b0, 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_near("xval", int'($signed(xval)), mon_e.ex_m);
                check_near("yval", int'($signed(yval)), mon_e.ey_m);
                check("aux", aux_out == mon_e.aux, int'(aux_out), int'(mon_e.aux));
            end
            n_results++;
            last_valid_cyc = cyc;
        end
        prev_valid = valid;
    end

    task automatic send(input int m, input logic [18:0] p, input logic a,
                        input int exm, input int eym, output int acc);
        int n;
        n = 0;
        acc = -1;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            check("accept_timeout", 1'b0, n, 200);
        end else begin
            stb = 1'b1;
            mag = m[11:0];
            ph = p;
            aux_in = a;
            sb.push_back('{ex_m: exm, ey_m: eym, aux: a});
            @(posedge clk);
            #1;
            acc = cyc;
            stb = 1'b0;
        end
    endtask

    task automatic wait_result(input int n0, input int acc, input bit chk_lat);
        int n;
        n = 0;
        while (n_results == n0 && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n_results == n0) check("result_timeout", 1'b0, n, 40);
        else if (chk_lat) check("latency", (last_valid_cyc - acc) == 17, last_valid_cyc - acc, 17);
    endtask

    task automatic send_model(input int m, input logic [18:0] p, input logic a, output int acc);
        send(m, p, a, model_m(m, p, 1'b0), model_m(m, p, 1'b1), acc);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        int acc, acc1, acc2, acc3, n0, m;
        logic [11:0] r12;
        logic [18:0] rp;
        logic [18:0] edge_ph[4];

        for (int k = 1; k <= 16; k++) gain = gain * $sqrt(1.0 + 1.0 / real'(64'd1 << (2 * k)));

        tbl[0] = '{2000,  19'h00000, 1'b1,  582,    0};
        tbl[1] = '{2000,  19'h20000, 1'b0,    0,  582};
        tbl[2] = '{2000,  19'h40000, 1'b1, -582,    0};
        tbl[3] = '{2000,  19'h60000, 1'b0,    0, -582};
        tbl[4] = '{2047,  19'h10000, 1'b1,  421,  421};
        tbl[5] = '{-2048, 19'h00000, 1'b0, -596,    0};
        tbl[6] = '{2000,  19'h7FFFF, 1'b1,  582,    0};
        tbl[7] = '{2000,  19'h0FFFF, 1'b0,  412,  412};
        tbl[8] = '{2000,  19'h10000, 1'b1,  412,  412};
        tbl[9] = '{-2048, 19'h7FFFF, 1'b0, -596,    0};

        #1 rst_n = 1'b0;
        #22;
        check("rst_busy", busy == 1'b0, int'(busy), 0);
        check("rst_valid", valid == 1'b0, int'(valid), 0);
        check("rst_xval", xval == 12'd0, int'(xval), 0);
        check("rst_yval", yval == 12'd0, int'(yval), 0);
        check("rst_aux", aux_out == 1'b0, int'(aux_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            n0 = n_results;
            send(tbl[i].m, tbl[i].p, tbl[i].a, tbl[i].ex * 1000, tbl[i].ey * 1000, acc);
            wait_result(n0, acc, 1'b1);
        end

        // Request while busy must be ignored; original result and aux come back.
        n0 = n_results;
        send_model(1234, 19'h2A5A5, 1'b1, acc);
        repeat (3) @(negedge clk);
        check("busy_mid_conv", busy == 1'b1, int'(busy), 1);
        stb = 1'b1;
        mag = 12'h8F0;
        ph = 19'h55555;
        aux_in = 1'b0;
        repeat (3) @(negedge clk);
        stb = 1'b0;
        wait_result(n0, acc, 1'b1);
        repeat (20) @(negedge clk);
        check("no_extra_result", n_results == n0 + 1, n_results - n0, 1);

        // Back-to-back at 18-clock spacing.
        n0 = n_results;
        send_model(-1500, 19'h13579, 1'b1, acc1);
        send_model(900,   19'h6ACE1, 1'b0, acc2);
        send_model(-333,  19'h3FFFF, 1'b1, acc3);
        check("b2b_spacing1", acc2 - acc1 == 18, acc2 - acc1, 18);
        check("b2b_spacing2", acc3 - acc2 == 18, acc3 - acc2, 18);
        wait_result(n0 + 2, acc3, 1'b1);
        check("b2b_count", n_results == n0 + 3, n_results - n0, 3);

        // Async reset during ROTATE iteration 7 discards the conversion.
        n0 = n_results;
        send_model(1500, 19'h23456, 1'b0, acc);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy == 1'b0, int'(busy), 0);
        check("mid_rst_valid", valid == 1'b0, int'(valid), 0);
        check("mid_rst_xval", xval == 12'd0, int'(xval), 0);
        check("mid_rst_yval", yval == 12'd0, int'(yval), 0);
        check("mid_rst_aux", aux_out == 1'b0, int'(aux_out), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("no_valid_after_rst", n_results == n0, n_results - n0, 0);
        n0 = n_results;
        send_model(1777, 19'h45678, 1'b1, acc);
        wait_result(n0, acc, 1'b1);

        // Random sweep, with quadrant-boundary phases mixed in.
        edge_ph[0] = 19'h7FFFF;
        edge_ph[1] = 19'h0FFFF;
        edge_ph[2] = 19'h10000;
        edge_ph[3] = 19'h00000;
        for (int i = 0; i < 1500; i++) begin
            r12 = 12'($urandom_range(0, 4095));
            m = int'($signed(r12));
            rp = (i % 10 < 4) ? edge_ph[i % 10] : 19'($urandom);
            n0 = n_results;
            send_model(m, rp, 1'($urandom), acc);
            wait_result(n0, acc, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size() == 0, sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
